// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and state encoding for the ram8 bank
package ram_pkg;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram8_bank_dmux8way.sv
// rtl/ram8_bank_dmux8way.sv - one-in, eight-out demultiplexer used as the load decoder
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  // route the single input onto the output picked by sel, all others low
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    e = 1'b0;
    f = 1'b0;
    g = 1'b0;
    h = 1'b0;
    case (sel)
      3'd0: a = in;
      3'd1: b = in;
      3'd2: c = in;
      3'd3: d = in;
      3'd4: e = in;
      3'd5: f = in;
      3'd6: g = in;
      default: h = in;
    endcase
  end

endmodule

// File: rtl/ram8_bank.sv
// rtl/ram8_bank.sv - eight-word register bank with decoded writes and a clear sweep
module ram8_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [DEPTH-1:0]  ld;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign busy = (state == CLEAR);

  // writes are locked out for the whole sweep by gating the decoder input
  DMux8Way u_dec (
    .in  (load & ~busy),
    .sel (address),
    .a   (ld[0]),
    .b   (ld[1]),
    .c   (ld[2]),
    .d   (ld[3]),
    .e   (ld[4]),
    .f   (ld[5]),
    .g   (ld[6]),
    .h   (ld[7])
  );

  // next-state logic: a clear request starts an 8-word sweep that cannot be extended
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // state and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // storage: the sweep zeroes word cnt, otherwise a decoded strobe captures in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy && (cnt == ADDR_W'(i))) begin
          mem[i] <= '0;
        end else if (ld[i]) begin
          mem[i] <= in;
        end
      end
    end
  end

  assign out = mem[address];

endmodule

// File: tb/tb_ram8_bank.sv
// tb/tb_ram8_bank.sv - self-checking bench for ram8_bank against a word-array model
module tb_ram8_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  int n_cmp;
  int n_bad;

  logic [15:0] model_mem [8];
  int          clear_left;

  ram8_bank #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a clear request owns the next eight edges, zeroing words in order
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
      clear_left = 0;
    end else if (clear_left > 0) begin
      model_mem[8 - clear_left] = 16'h0000;
      clear_left = clear_left - 1;
    end else begin
      if (load) model_mem[address] = in;
      if (clear) clear_left = 8;
    end
  end

  // per-cycle compare of both outputs against the model
  always @(posedge clk) begin
    #1;
    chk("cycle_out", {16'h0, out}, {16'h0, model_mem[address]});
    chk("cycle_busy", {31'h0, busy}, {31'h0, (clear_left > 0)});
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    load = 1'b1;
    address = a;
    in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(nm, {16'h0, out}, {16'h0, exp});
  endtask

  int          busy_cnt;
  logic [15:0] word_exp;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_left = 0;
    for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
    rst_n = 1'b1;
    in = 16'h0;
    load = 1'b0;
    address = 3'd0;
    clear = 1'b0;
    #1 rst_n = 1'b0;

    // reset: every address reads zero, not busy
    for (int a = 0; a < 8; a++) begin
      rd("reset_out", 3'(a), 16'h0000);
      chk("reset_busy", {31'h0, busy}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // single write to address 5
    wr(3'd5, 16'h1234);
    for (int a = 0; a < 8; a++) begin
      word_exp = (a == 5) ? 16'h1234 : 16'h0000;
      rd("single_rd", 3'(a), word_exp);
    end
    @(negedge clk);
    load = 1'b0;
    in = 16'hFFFF;
    address = 3'd5;
    @(negedge clk);
    rd("no_load_hold", 3'd5, 16'h1234);

    // full-bank write then read-back
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
    for (int i = 0; i < 8; i++) rd("bank_rd", 3'(i), 16'(16'h1111 * (i + 1)));
    wr(3'd2, 16'hAAAA);
    wr(3'd2, 16'h5555);
    rd("overwrite", 3'd2, 16'h5555);

    // clear together with a write to address 3
    @(negedge clk);
    clear = 1'b1;
    load = 1'b1;
    address = 3'd3;
    in = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("clr_same_edge_wr", {16'h0, out}, 32'h0000BEEF);
    chk("clr_busy_rise", {31'h0, busy}, 32'h1);
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 20 && busy; k++) begin
      @(negedge clk);
      clear = (k == 3);
      load = (k == 1);
      address = 3'd2;
      in = 16'hDEAD;
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
    end
    @(negedge clk);
    clear = 1'b0;
    load = 1'b0;
    chk("clr_busy_len", busy_cnt, 8);
    for (int a = 0; a < 8; a++) rd("after_clear", 3'(a), 16'h0000);

    // reset in the middle of a sweep
    wr(3'd6, 16'h7777);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    address = 3'd6;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    chk("pre_rst_out", {16'h0, out}, 32'h00007777);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_out", {16'h0, out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    wr(3'd7, 16'h00AA);
    rd("post_rst_wr", 3'd7, 16'h00AA);
    rd("post_rst_w6", 3'd6, 16'h0000);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
